game_input_conditioner: RTL and testbench
=========================================

Name: game_input_conditioner

Overview:
Input-conditioning stage between the raw player buttons on ui_in and the game core inside tt_um_pckys_game. Per button it synchronises, debounces and produces a clean level plus single-cycle press, release and auto-repeat pulses. A shared prescaler generates the time base, so the per-button counters stay narrow enough for the tile area budget.

Parameters:
N_BTN, 4, number of button channels
PRESCALE, 10000, clk cycles per tick (1 ms at 10 MHz); must be ≥2
DEB_TICKS, 5, consecutive ticks a changed input must persist before the level flips; must be ≥1
REPEAT_DELAY_TICKS, 500, ticks from press to the first repeat pulse; must be ≥1
REPEAT_RATE_TICKS, 100, ticks between subsequent repeat pulses; must be ≥1

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes the time base and masks pulse outputs
btn_raw  input  N_BTN  asynchronous button inputs, active high
btn_level  output  N_BTN  debounced level
btn_press  output  N_BTN  one-clk pulse on a debounced rising edge
btn_release  output  N_BTN  one-clk pulse on a debounced falling edge
btn_repeat  output  N_BTN  one-clk auto-repeat pulse while held

Behaviour:
- Reset: rst_n low clears everything asynchronously. This covers the sync flops, prescaler, debounce counters, levels, repeat FSMs and all outputs, which go to 0.
- Synchroniser: 2-flop chain per bit. Raw-to-sync latency is 2 clk. Runs regardless of ena.
- Prescaler: counter runs 0..PRESCALE-1 while ena=1 and wraps to 0.
  - tick is high for exactly the one clk in which the count equals PRESCALE-1.
  - ena=0 holds the count and forces tick to 0.
- Debounce, per bit i, with stable level L[i] and counter dcnt[i] of width clog2(DEB_TICKS+1):
  - sync[i]==L[i]: dcnt cleared every clk.
  - sync[i]!=L[i] and tick: if dcnt==DEB_TICKS-1, L toggles and dcnt is cleared; otherwise dcnt increments.
  - A glitch shorter than DEB_TICKS ticks never changes L.
- Edge pulses: btn_press[i] is high on the single clk after the edge that sets L[i] 0→1 (registered alongside L). btn_release[i] is the same for 1→0.
- Repeat FSM, per bit, with states IDLE, DELAY and RPT, plus counter rcnt sized for max(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS):
  - IDLE → DELAY on the edge where L rises; rcnt=0.
  - DELAY, on tick: when rcnt==REPEAT_DELAY_TICKS-1, btn_repeat pulses next clk, go to RPT with rcnt=0. Otherwise rcnt++.
  - RPT, on tick: when rcnt==REPEAT_RATE_TICKS-1, btn_repeat pulses and rcnt=0. Otherwise rcnt++.
  - L falling returns the FSM to IDLE from any state on the same edge.
  - If L falls on the same edge a repeat would fire, release wins and no repeat pulse is emitted.
- Press and the first repeat can never coincide, because they are at least 1 tick ≥ PRESCALE clk apart.
- ena=0: L, dcnt, rcnt and FSM state hold. btn_press, btn_release and btn_repeat are forced to 0; btn_level still reflects L. Edges whose pulse fell inside an ena-low window are lost and are not replayed.
- Channels are fully independent; simultaneous events on different bits are all reported in the same clk.
- Reset mid-press with the button still held: L=0 after reset, so a fresh press is reported after 2 clk plus DEB_TICKS ticks.

Test Plan:
All scenarios use PRESCALE=4, DEB_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, ena=1 unless stated.
- Reset: rst_n=0 with btn_raw=4'hF, then release → all outputs 0 for ≥2 clk. btn_level=4'hF appears within 2+3×4+4 clk, with exactly one btn_press pulse per bit in that same clk.
- Glitch reject: btn_raw[0] high for 8 clk (≤2 ticks), then low → btn_level[0] and btn_press[0] stay 0 throughout.
- Hold/repeat: hold btn_raw[1] for 80 clk →
  - one btn_press[1];
  - first btn_repeat[1] exactly 20 clk (5 ticks) after press;
  - further repeats every 8 clk;
  - after raw falls, one btn_release[1] ~12–16 clk later, with no repeat on or after it.
- Simultaneous: bits 2 and 3 asserted on the same clk → press pulses coincide in one clk; release of bit 2 while bit 3 is held leaves bit 3's repeat cadence unchanged.
- Enable gating: hold button, drop ena for 40 clk mid-DELAY → no pulses and no tick progress while low. On ena=1, the first repeat occurs 20 clk of enabled time after press.
- Async reset mid-RPT: assert rst_n low between clk edges → outputs 0 immediately, not at the next edge; FSM restarts from IDLE.

Source files
------------

// File: rtl/game_input_conditioner.sv
// Button conditioning for the game core: each button is synchronised and
// debounced into a clean level. The stage also produces one-clk press,
// release and auto-repeat pulses. A single shared prescaler supplies the
// tick time base, which keeps the per-button counters narrow.
module game_input_conditioner #(
  parameter int unsigned N_BTN              = 4,
  parameter int unsigned PRESCALE           = 10000,
  parameter int unsigned DEB_TICKS          = 5,
  parameter int unsigned REPEAT_DELAY_TICKS = 500,
  parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DCNT_W   = $clog2(DEB_TICKS + 1);
  localparam int unsigned RPT_MAX  = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                     REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int unsigned RCNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(PRESCALE - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEB_TICKS - 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_e;

  logic [N_BTN-1:0]  sync_meta;
  logic [N_BTN-1:0]  sync_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              tick_c;

  logic [N_BTN-1:0]  lvl_q;
  logic [N_BTN-1:0]  lvl_d;
  logic [DCNT_W-1:0] dcnt_q [N_BTN];
  logic [DCNT_W-1:0] dcnt_d [N_BTN];
  logic [N_BTN-1:0]  rise_c;
  logic [N_BTN-1:0]  fall_c;

  rpt_state_e        state_q [N_BTN];
  rpt_state_e        state_d [N_BTN];
  logic [RCNT_W-1:0] rcnt_q  [N_BTN];
  logic [RCNT_W-1:0] rcnt_d  [N_BTN];
  logic [N_BTN-1:0]  fire_c;

  logic [N_BTN-1:0]  press_q;
  logic [N_BTN-1:0]  release_q;
  logic [N_BTN-1:0]  repeat_q;

  // Two-flop synchroniser; runs independent of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Shared prescaler; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (ena) begin
      pcnt_q <= (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_W'(1);
    end
  end

  assign tick_c = ena && (pcnt_q == PCNT_LAST);

  // Debounce next-state: a differing input must persist DEB_TICKS ticks to flip the level.
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    rise_c = '0;
    fall_c = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (ena) begin
        if (sync_q[i] == lvl_q[i]) begin
          dcnt_d[i] = '0;
        end else if (tick_c) begin
          if (dcnt_q[i] == DCNT_LAST) begin
            lvl_d[i]  = ~lvl_q[i];
            dcnt_d[i] = '0;
            rise_c[i] = ~lvl_q[i];
            fall_c[i] = lvl_q[i];
          end else begin
            dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
          end
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
      for (int i = 0; i < int'(N_BTN); i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // Repeat FSM next-state; a falling level overrides everything, so release beats a due repeat.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    fire_c  = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      if (fall_c[i]) begin
        state_d[i] = RPT_IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          RPT_IDLE: begin
            if (rise_c[i]) begin
              state_d[i] = RPT_DELAY;
              rcnt_d[i]  = '0;
            end
          end
          RPT_DELAY: begin
            if (tick_c) begin
              if (rcnt_q[i] == DELAY_LAST) begin
                fire_c[i]  = 1'b1;
                state_d[i] = RPT_RUN;
                rcnt_d[i]  = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
              end
            end
          end
          RPT_RUN: begin
            if (tick_c) begin
              if (rcnt_q[i] == RATE_LAST) begin
                fire_c[i] = 1'b1;
                rcnt_d[i] = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
              end
            end
          end
          default: begin
            state_d[i] = RPT_IDLE;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= RPT_IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Pulse registers, updated on the same edge as the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      press_q   <= rise_c;
      release_q <= fall_c;
      repeat_q  <= fire_c;
    end
  end

  // Pulses vanish as soon as ena drops; a pulse landing in an ena-low cycle is lost.
  assign btn_level   = lvl_q;
  assign btn_press   = press_q   & {N_BTN{ena}};
  assign btn_release = release_q & {N_BTN{ena}};
  assign btn_repeat  = repeat_q  & {N_BTN{ena}};

endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed bench for game_input_conditioner with a short time base
// (PRESCALE=4, DEB=3, DELAY=5, RATE=2). Cycle numbers are counted from the
// release of reset; expected values are hand-derived for that phase.
module tb_game_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_repeat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int press_cnt  [4];
  int rel_cnt    [4];
  int rpt_cnt    [4];
  int last_press [4];
  int last_rel   [4];
  int first_rpt  [4];
  int last_rpt   [4];
  int gap_err    [4];
  int rpt_bad    [4];
  int lvl_seen   [4];
  int off_pulse;

  game_input_conditioner #(
    .N_BTN(4),
    .PRESCALE(4),
    .DEB_TICKS(3),
    .REPEAT_DELAY_TICKS(5),
    .REPEAT_RATE_TICKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_trk();
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]  = 0;
      rel_cnt[i]    = 0;
      rpt_cnt[i]    = 0;
      last_press[i] = -1;
      last_rel[i]   = -1;
      first_rpt[i]  = -1;
      last_rpt[i]   = -1;
      gap_err[i]    = 0;
      rpt_bad[i]    = 0;
      lvl_seen[i]   = 0;
    end
    off_pulse = 0;
  endtask

  // One clock; sample 1 time unit after the edge and log pulse activity.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (btn_level[i]) lvl_seen[i] = 1;
      if (btn_press[i]) begin
        press_cnt[i]++;
        last_press[i] = cyc;
      end
      if (btn_release[i]) begin
        rel_cnt[i]++;
        last_rel[i] = cyc;
      end
      if (btn_repeat[i]) begin
        if (rpt_cnt[i] == 0) first_rpt[i] = cyc;
        else if (cyc - last_rpt[i] != 8) gap_err[i]++;
        last_rpt[i] = cyc;
        rpt_cnt[i]++;
        if (!btn_level[i]) rpt_bad[i]++;
      end
    end
    if (!ena && (btn_press | btn_release | btn_repeat) != 4'h0) off_pulse++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Reset with raw inputs at the given value; releases between edges.
  task automatic do_reset(input logic [3:0] raw);
    rst_n   = 1'b0;
    btn_raw = raw;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    clear_trk();
  endtask

  initial begin
    rst_n   = 1'b0;
    ena     = 1'b1;
    btn_raw = 4'hF;
    clear_trk();

    // Reset with all buttons held, then a fresh debounced press on every bit.
    step();
    step();
    chk("rst_outs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    rst_n = 1'b1;
    cyc   = 0;
    clear_trk();
    step();
    chk("rst_hold1", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    step();
    chk("rst_hold2", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    while (cyc < 18 && btn_level == 4'h0) step();
    chk("rst_level", 32'(btn_level), 32'hF);
    chk("rst_latency", cyc, 12);
    chk("rst_press", 32'(btn_press), 32'hF);
    step();
    chk("rst_press_once", 32'(btn_press), 32'h0);

    // Glitch of 8 clk on bit 0 must be rejected.
    do_reset(4'h0);
    btn_raw = 4'b0001;
    run_to(8);
    btn_raw = 4'b0000;
    run_to(30);
    chk("glitch_level", lvl_seen[0], 0);
    chk("glitch_press", press_cnt[0], 0);

    // Hold bit 1 for 80 clk: press at 12, repeats 32..88 every 8, release at 92.
    do_reset(4'h0);
    btn_raw = 4'b0010;
    run_to(80);
    btn_raw = 4'b0000;
    run_to(120);
    chk("hold_press_cnt", press_cnt[1], 1);
    chk("hold_press_at", last_press[1], 12);
    chk("hold_first_rpt", first_rpt[1] - last_press[1], 20);
    chk("hold_rpt_gap", gap_err[1], 0);
    chk("hold_rpt_cnt", rpt_cnt[1], 8);
    chk("hold_rel_cnt", rel_cnt[1], 1);
    chk("hold_rel_delay", last_rel[1] - 80, 12);
    chk("hold_rpt_after_rel", rpt_bad[1], 0);

    // Bits 2 and 3 together; bit 2 dropped at 40 while bit 3 keeps repeating.
    do_reset(4'h0);
    btn_raw = 4'b1100;
    run_to(40);
    btn_raw = 4'b1000;
    run_to(100);
    chk("sim_press2", press_cnt[2], 1);
    chk("sim_press3_at", last_press[3], 12);
    chk("sim_press_same", last_press[2], 12);
    chk("sim_rel2_at", last_rel[2], 52);
    chk("sim_rpt2_cnt", rpt_cnt[2], 3);
    chk("sim_rpt3_cnt", rpt_cnt[3], 9);
    chk("sim_rpt3_gap", gap_err[3], 0);
    chk("sim_level3", 32'(btn_level), 32'h8);
    btn_raw = 4'b0000;
    run_to(130);

    // ena low for 40 clk during DELAY: first repeat shifts by exactly 40 clk.
    do_reset(4'h0);
    btn_raw = 4'b0001;
    run_to(22);
    ena = 1'b0;
    run_to(40);
    chk("ena_level_held", 32'(btn_level), 32'h1);
    run_to(62);
    chk("ena_no_rpt_low", rpt_cnt[0], 0);
    ena = 1'b1;
    run_to(90);
    chk("ena_off_pulses", off_pulse, 0);
    chk("ena_press_at", last_press[0], 12);
    chk("ena_first_rpt", first_rpt[0], 72);
    chk("ena_rpt_cnt", rpt_cnt[0], 3);
    btn_raw = 4'b0000;
    run_to(120);

    // Asynchronous reset mid-RPT, button still held afterwards.
    do_reset(4'h0);
    btn_raw = 4'b0010;
    run_to(40);
    chk("art_pre_rpt", 32'(btn_repeat), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("art_async", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    clear_trk();
    run_to(40);
    chk("art_press_at", last_press[1], 12);
    chk("art_first_rpt", first_rpt[1], 32);
    chk("art_rpt_cnt", rpt_cnt[1], 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
